// File: rtl/motor_sequencer.sv
// Direction command sequencer for the two-channel motor PWM stage: decodes commands,
// inserts coast dead-time between directions, ramps duty from zero and stops on a silent host.
module motor_sequencer #(
    parameter int unsigned DEAD_CYC  = 100000,
    parameter int unsigned RAMP_DIV  = 500000,
    parameter int unsigned RAMP_STEP = 32,
    parameter int unsigned DUTY_MAX  = 600,
    parameter int unsigned TIMEOUT   = 50000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    input  logic [3:0] cmd_mode,
    output logic [1:0] r_IN,
    output logic [1:0] l_IN,
    output logic [9:0] right_duty,
    output logic [9:0] left_duty,
    output logic [1:0] state,
    output logic       timeout_flag
);

    localparam int unsigned DUTY_W = 10;
    localparam int unsigned SUM_W  = DUTY_W + 1;
    localparam int unsigned CNT_W  = 32;

    localparam logic [CNT_W-1:0]  DEAD_LAST = CNT_W'(DEAD_CYC - 1);
    localparam logic [CNT_W-1:0]  STEP_LAST = CNT_W'(RAMP_DIV - 1);
    localparam logic [CNT_W-1:0]  WD_TERM   = CNT_W'(TIMEOUT);
    localparam logic [SUM_W-1:0]  STEP_INC  = SUM_W'(RAMP_STEP);
    localparam logic [SUM_W-1:0]  SUM_CAP   = SUM_W'(DUTY_MAX);
    localparam logic [DUTY_W-1:0] DUTY_TOP  = DUTY_W'(DUTY_MAX);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RAMP  = 2'd1,
        ST_RUN   = 2'd2,
        ST_BRAKE = 2'd3
    } state_e;

    typedef enum logic [2:0] {
        TGT_STOP  = 3'd0,
        TGT_UP    = 3'd1,
        TGT_DOWN  = 3'd2,
        TGT_LEFT  = 3'd3,
        TGT_RIGHT = 3'd4
    } target_e;

    state_e             st_q, st_n;
    target_e            tgt_q, tgt_n, cmd_tgt;
    logic [DUTY_W-1:0]  duty_q, duty_n;
    logic [CNT_W-1:0]   step_q, step_n;
    logic [CNT_W-1:0]   dead_q, dead_n;
    logic [CNT_W-1:0]   wd_q, wd_n, wd_inc;
    logic               flag_q, flag_n;
    logic [SUM_W-1:0]   ramp_sum;

    logic [1:0]         r_n, l_n;
    logic [DUTY_W-1:0]  rd_n, ld_n;

    function automatic target_e decode(input logic [3:0] mode);
        target_e t;
        case (mode)
            4'b0010:                   t = TGT_UP;
            4'b1000:                   t = TGT_DOWN;
            4'b0001, 4'b0011, 4'b0101: t = TGT_LEFT;
            4'b0100, 4'b0110, 4'b0111: t = TGT_RIGHT;
            default:                   t = TGT_STOP;
        endcase
        return t;
    endfunction

    // Next-state, target, duty and counter update
    always_comb begin
        st_n     = st_q;
        tgt_n    = tgt_q;
        duty_n   = duty_q;
        step_n   = step_q;
        dead_n   = dead_q;
        wd_n     = wd_q;
        flag_n   = flag_q;
        cmd_tgt  = decode(cmd_mode);
        ramp_sum = {1'b0, duty_q} + STEP_INC;
        wd_inc   = wd_q + CNT_W'(1);

        if (cmd_valid) begin
            flag_n = 1'b0;
            wd_n   = '0;
        end

        case (st_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    tgt_n = cmd_tgt;
                    if (cmd_tgt != TGT_STOP) begin
                        st_n   = ST_RAMP;
                        duty_n = '0;
                        step_n = '0;
                    end
                end
            end

            ST_RAMP, ST_RUN: begin
                if (cmd_valid && (cmd_tgt != tgt_q)) begin
                    tgt_n  = cmd_tgt;
                    st_n   = ST_BRAKE;
                    dead_n = '0;
                end else if (!cmd_valid && (wd_inc == WD_TERM)) begin
                    tgt_n  = TGT_STOP;
                    flag_n = 1'b1;
                    st_n   = ST_BRAKE;
                    dead_n = '0;
                end else begin
                    if (!cmd_valid) begin
                        wd_n = wd_inc;
                    end
                    if (st_q == ST_RAMP) begin
                        if (step_q == STEP_LAST) begin
                            step_n = '0;
                            // Saturate at 11 bits so the sum can never wrap past DUTY_MAX
                            if (ramp_sum >= SUM_CAP) begin
                                duty_n = DUTY_TOP;
                                st_n   = ST_RUN;
                            end else begin
                                duty_n = ramp_sum[DUTY_W-1:0];
                            end
                        end else begin
                            step_n = step_q + CNT_W'(1);
                        end
                    end
                end
            end

            ST_BRAKE: begin
                if (cmd_valid) begin
                    tgt_n = cmd_tgt;
                end
                if (dead_q == DEAD_LAST) begin
                    dead_n = '0;
                    if (tgt_n == TGT_STOP) begin
                        st_n = ST_IDLE;
                    end else begin
                        st_n   = ST_RAMP;
                        duty_n = '0;
                        step_n = '0;
                        wd_n   = '0;
                    end
                end else begin
                    dead_n = dead_q + CNT_W'(1);
                end
            end

            default: st_n = ST_IDLE;
        endcase
    end

    // Pin and duty values for the state being entered, so they register alongside it
    always_comb begin
        r_n  = 2'b00;
        l_n  = 2'b00;
        rd_n = '0;
        ld_n = '0;
        if ((st_n == ST_RAMP) || (st_n == ST_RUN)) begin
            case (tgt_n)
                TGT_UP:    begin r_n = 2'b10; rd_n = duty_n; end
                TGT_DOWN:  begin r_n = 2'b01; rd_n = duty_n; end
                TGT_LEFT:  begin l_n = 2'b10; ld_n = duty_n; end
                TGT_RIGHT: begin l_n = 2'b01; ld_n = duty_n; end
                default:   begin r_n = 2'b00; l_n = 2'b00; end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q       <= ST_IDLE;
            tgt_q      <= TGT_STOP;
            duty_q     <= '0;
            step_q     <= '0;
            dead_q     <= '0;
            wd_q       <= '0;
            flag_q     <= 1'b0;
            r_IN       <= 2'b00;
            l_IN       <= 2'b00;
            right_duty <= '0;
            left_duty  <= '0;
        end else begin
            st_q       <= st_n;
            tgt_q      <= tgt_n;
            duty_q     <= duty_n;
            step_q     <= step_n;
            dead_q     <= dead_n;
            wd_q       <= wd_n;
            flag_q     <= flag_n;
            r_IN       <= r_n;
            l_IN       <= l_n;
            right_duty <= rd_n;
            left_duty  <= ld_n;
        end
    end

    assign state        = st_q;
    assign timeout_flag = flag_q;

endmodule

// File: tb/tb_motor_sequencer.sv
// Self-checking bench for motor_sequencer: per-cycle expectations queued at drive time,
// compared one cycle later; code map is table driven.
module tb_motor_sequencer;

    localparam int unsigned DEAD_CYC  = 4;
    localparam int unsigned RAMP_DIV  = 3;
    localparam int unsigned RAMP_STEP = 100;
    localparam int unsigned DUTY_MAX  = 600;
    localparam int unsigned TIMEOUT   = 50;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RAMP  = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_BRAKE = 2'd3;

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic [3:0] cmd_mode;
    logic [1:0] r_IN;
    logic [1:0] l_IN;
    logic [9:0] right_duty;
    logic [9:0] left_duty;
    logic [1:0] state;
    logic       timeout_flag;

    int n_checks;
    int n_pass;

    typedef struct {
        logic [1:0] st;
        logic [1:0] r;
        logic [1:0] l;
        logic [9:0] rd;
        logic [9:0] ld;
        logic       fl;
        string      nm;
    } exp_t;

    exp_t exp_q[$];

    typedef struct packed {
        logic [3:0] mode;
        logic [1:0] st;
        logic [1:0] r;
        logic [1:0] l;
    } map_t;

    map_t map_tbl[16];

    motor_sequencer #(
        .DEAD_CYC (DEAD_CYC),
        .RAMP_DIV (RAMP_DIV),
        .RAMP_STEP(RAMP_STEP),
        .DUTY_MAX (DUTY_MAX),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_mode    (cmd_mode),
        .r_IN        (r_IN),
        .l_IN        (l_IN),
        .right_duty  (right_duty),
        .left_duty   (left_duty),
        .state       (state),
        .timeout_flag(timeout_flag)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL time_limit: got no summary by %0t, want finish earlier", $time);
        $fatal(1);
    end

    function automatic logic [9:0] ramp_duty(input int k);
        int d;
        d = int'(RAMP_STEP) * (k / int'(RAMP_DIV));
        if (d > int'(DUTY_MAX)) d = int'(DUTY_MAX);
        return 10'(d);
    endfunction

    task automatic check_out();
        exp_t e;
        n_checks++;
        if (exp_q.size() == 0) begin
            $display("FAIL scoreboard_empty: got no expectation, want one queued");
            return;
        end
        e = exp_q.pop_front();
        if ({state, r_IN, l_IN, right_duty, left_duty, timeout_flag} ===
            {e.st, e.r, e.l, e.rd, e.ld, e.fl}) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got st=%0d r=%b l=%b rd=%0d ld=%0d fl=%b, want st=%0d r=%b l=%b rd=%0d ld=%0d fl=%b",
                     e.nm, state, r_IN, l_IN, right_duty, left_duty, timeout_flag,
                     e.st, e.r, e.l, e.rd, e.ld, e.fl);
        end
    endtask

    // Drive one cycle of stimulus and queue the outputs expected in the following cycle
    task automatic cyc(input logic v, input logic [3:0] m,
                       input logic [1:0] st, input logic [1:0] r, input logic [1:0] l,
                       input logic [9:0] rd, input logic [9:0] ld, input logic fl,
                       input string nm);
        exp_t e;
        cmd_valid = v;
        cmd_mode  = m;
        e.st = st; e.r = r; e.l = l; e.rd = rd; e.ld = ld; e.fl = fl; e.nm = nm;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_mode  = 4'b0000;
        check_out();
    endtask

    task automatic brake_then_idle(input string nm);
        cyc(1'b1, 4'b0000, S_BRAKE, 2'b00, 2'b00, 10'd0, 10'd0, 1'b0, nm);
        for (int i = 0; i < 3; i++)
            cyc(1'b0, 4'b0000, S_BRAKE, 2'b00, 2'b00, 10'd0, 10'd0, 1'b0, nm);
        cyc(1'b0, 4'b0000, S_IDLE, 2'b00, 2'b00, 10'd0, 10'd0, 1'b0, nm);
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_mode  = 4'b0000;

        map_tbl[0]  = '{4'b0000, S_IDLE, 2'b00, 2'b00};
        map_tbl[1]  = '{4'b0001, S_RAMP, 2'b00, 2'b10};
        map_tbl[2]  = '{4'b0010, S_RAMP, 2'b10, 2'b00};
        map_tbl[3]  = '{4'b0011, S_RAMP, 2'b00, 2'b10};
        map_tbl[4]  = '{4'b0100, S_RAMP, 2'b00, 2'b01};
        map_tbl[5]  = '{4'b0101, S_RAMP, 2'b00, 2'b10};
        map_tbl[6]  = '{4'b0110, S_RAMP, 2'b00, 2'b01};
        map_tbl[7]  = '{4'b0111, S_RAMP, 2'b00, 2'b01};
        map_tbl[8]  = '{4'b1000, S_RAMP, 2'b01, 2'b00};
        map_tbl[9]  = '{4'b1001, S_IDLE, 2'b00, 2'b00};
        map_tbl[10] = '{4'b1010, S_IDLE, 2'b00, 2'b00};
        map_tbl[11] = '{4'b1011, S_IDLE, 2'b00, 2'b00};
        map_tbl[12] = '{4'b1100, S_IDLE, 2'b00, 2'b00};
        map_tbl[13] = '{4'b1101, S_IDLE, 2'b00, 2'b00};
        map_tbl[14] = '{4'b1110, S_IDLE, 2'b00, 2'b00};
        map_tbl[15] = '{4'b1111, S_IDLE, 2'b00, 2'b00};

        @(posedge clk);
        #1;
        cyc(1'b0, 4'b0000, S_IDLE, 2'b00, 2'b00, 10'd0, 10'd0, 1'b0, "reset_init");
        rst = 1'b0;

        // Ramp from idle on UP
        cyc(1'b1, 4'b0010, S_RAMP, 2'b10, 2'b00, 10'd0, 10'd0, 1'b0, "ramp_entry");
        for (int k = 1; k <= 19; k++)
            cyc(1'b0, 4'b0000, (k + 1 >= 19) ? S_RUN : S_RAMP, 2'b10, 2'b00,
                ramp_duty(k), 10'd0, 1'b0, "ramp_up");

        // Repeated same-target strobes in RUN: no brake, no watchdog
        for (int i = 0; i < 60; i++)
            cyc((i % 20) == 0, 4'b0010, S_RUN, 2'b10, 2'b00, 10'd600, 10'd0, 1'b0, "run_refresh");

        // Reversal UP -> DOWN through dead time
        cyc(1'b1, 4'b1000, S_BRAKE, 2'b00, 2'b00, 10'd0, 10'd0, 1'b0, "rev_brake");
        for (int i = 0; i < 3; i++)
            cyc(1'b0, 4'b0000, S_BRAKE, 2'b00, 2'b00, 10'd0, 10'd0, 1'b0, "rev_brake");
        cyc(1'b0, 4'b0000, S_RAMP, 2'b01, 2'b00, 10'd0, 10'd0, 1'b0, "rev_ramp0");
        for (int j = 1; j <= 6; j++)
            cyc(1'b0, 4'b0000, S_RAMP, 2'b01, 2'b00, ramp_duty(j), 10'd0, 1'b0, "rev_ramp");

        // Back to UP, then retarget during BRAKE ending at STOP
        cyc(1'b1, 4'b0010, S_BRAKE, 2'b00, 2'b00, 10'd0, 10'd0, 1'b0, "to_up_brake");
        for (int i = 0; i < 3; i++)
            cyc(1'b0, 4'b0000, S_BRAKE, 2'b00, 2'b00, 10'd0, 10'd0, 1'b0, "to_up_brake");
        cyc(1'b0, 4'b0000, S_RAMP, 2'b10, 2'b00, 10'd0, 10'd0, 1'b0, "to_up_ramp");
        cyc(1'b1, 4'b0000, S_BRAKE, 2'b00, 2'b00, 10'd0, 10'd0, 1'b0, "retgt_brake");
        cyc(1'b1, 4'b0001, S_BRAKE, 2'b00, 2'b00, 10'd0, 10'd0, 1'b0, "retgt_left");
        cyc(1'b1, 4'b0000, S_BRAKE, 2'b00, 2'b00, 10'd0, 10'd0, 1'b0, "retgt_stop");
        cyc(1'b0, 4'b0000, S_BRAKE, 2'b00, 2'b00, 10'd0, 10'd0, 1'b0, "retgt_last");
        for (int i = 0; i < 3; i++)
            cyc(1'b0, 4'b0000, S_IDLE, 2'b00, 2'b00, 10'd0, 10'd0, 1'b0, "retgt_idle");

        // Watchdog: RIGHT via 0111, no further strobes
        for (int k = 0; k < 50; k++)
            cyc(k == 0, 4'b0111, (k + 1 >= 19) ? S_RUN : S_RAMP, 2'b00, 2'b01,
                10'd0, ramp_duty(k), 1'b0, "wd_run");
        for (int i = 0; i < 4; i++)
            cyc(1'b0, 4'b0000, S_BRAKE, 2'b00, 2'b00, 10'd0, 10'd0, 1'b1, "wd_brake");
        cyc(1'b0, 4'b0000, S_IDLE, 2'b00, 2'b00, 10'd0, 10'd0, 1'b1, "wd_idle");
        cyc(1'b1, 4'b1111, S_IDLE, 2'b00, 2'b00, 10'd0, 10'd0, 1'b0, "wd_clear_1111");

        // Command at the BRAKE exit cycle decides the destination
        cyc(1'b1, 4'b0010, S_RAMP, 2'b10, 2'b00, 10'd0, 10'd0, 1'b0, "exit_up");
        cyc(1'b1, 4'b0000, S_BRAKE, 2'b00, 2'b00, 10'd0, 10'd0, 1'b0, "exit_brake");
        for (int i = 0; i < 3; i++)
            cyc(1'b0, 4'b0000, S_BRAKE, 2'b00, 2'b00, 10'd0, 10'd0, 1'b0, "exit_brake");
        cyc(1'b1, 4'b1000, S_RAMP, 2'b01, 2'b00, 10'd0, 10'd0, 1'b0, "exit_down");
        brake_then_idle("exit_stop");

        // Code map table from IDLE
        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, map_tbl[i].mode, map_tbl[i].st, map_tbl[i].r, map_tbl[i].l,
                10'd0, 10'd0, 1'b0, $sformatf("map_%b", map_tbl[i].mode));
            if (map_tbl[i].st == S_RAMP)
                brake_then_idle("map_stop");
        end

        // Strobe on the watchdog terminal cycle wins, then reset from RUN
        for (int k = 0; k <= 60; k++)
            cyc((k == 0) || (k == 50), 4'b0101, (k + 1 >= 19) ? S_RUN : S_RAMP, 2'b00, 2'b10,
                10'd0, ramp_duty(k), 1'b0, "wd_race");
        rst = 1'b1;
        cyc(1'b0, 4'b0000, S_IDLE, 2'b00, 2'b00, 10'd0, 10'd0, 1'b0, "reset_run");
        cyc(1'b0, 4'b0000, S_IDLE, 2'b00, 2'b00, 10'd0, 10'd0, 1'b0, "reset_run");
        rst = 1'b0;
        cyc(1'b0, 4'b0000, S_IDLE, 2'b00, 2'b00, 10'd0, 10'd0, 1'b0, "after_reset");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/motor_sequencer.md
# motor_sequencer

Command sequencer in front of the two-channel motor PWM stage. Accepts 4-bit direction commands from the input/control logic and produces direction pins and 10-bit duty values for the left and right `motor_pwm` instances. On every command change it inserts a coast (dead-time) interval, ramps the new axis up from zero duty, and stops the car if commands stop arriving (watchdog).

## Interface

All parameters are in `clk` cycles unless stated.

**Parameters**
- `DEAD_CYC`, default 100000: cycles both bridges are held off between any two driven directions.
- `RAMP_DIV`, default 500000: cycles between duty increments during ramp-up.
- `RAMP_STEP`, default 32: duty increment per ramp step.
- `DUTY_MAX`, default 600: final running duty. Must be ≤ 1023 and ≥ `RAMP_STEP`.
- `TIMEOUT`, default 50000000: watchdog period.

**Ports**
- `clk`, in, 1: system clock. Single clock domain.
- `rst`, in, 1: synchronous, active-high reset.
- `cmd_valid`, in, 1: one-cycle strobe qualifying `cmd_mode`.
- `cmd_mode`, in, 4: direction code.
- `r_IN`, out, 2: right (up/down) bridge direction pins.
- `l_IN`, out, 2: left (left/right) bridge direction pins.
- `right_duty`, out, 10: duty to the right PWM generator.
- `left_duty`, out, 10: duty to the left PWM generator.
- `state`, out, 2: IDLE=0, RAMP=1, RUN=2, BRAKE=3.
- `timeout_flag`, out, 1: set when the watchdog fired; cleared by the next `cmd_valid`.

## Operation

**Command decode** (registered as `target` when `cmd_valid`=1):
- 0000 → STOP.
- 0010 → UP: right axis, `r_IN`=10.
- 1000 → DOWN: right axis, `r_IN`=01.
- 0001, 0011, 0101 → LEFT: left axis, `l_IN`=10.
- 0100, 0110, 0111 → RIGHT: left axis, `l_IN`=01.
- Any other code → STOP.

**Outputs by state:**
- IDLE and BRAKE: `r_IN`=`l_IN`=00, both duties 0.
- RAMP and RUN: the active axis drives its pins and the ramp duty. The inactive axis has pins 00 and duty 0.

**State transitions:**
- IDLE: a `cmd_valid` with a non-STOP target → RAMP, duty 0, step counter 0. STOP commands leave the block in IDLE.
- RAMP: every `RAMP_DIV` cycles, duty ← min(duty+`RAMP_STEP`, `DUTY_MAX`). The same edge that reaches `DUTY_MAX` moves to RUN.
- RUN: hold `DUTY_MAX`.
- RAMP/RUN, `cmd_valid` with the same target: no change except watchdog refresh.
- RAMP/RUN, `cmd_valid` with a different target (including STOP): → BRAKE, dead counter 0.
- BRAKE: lasts exactly `DEAD_CYC` cycles.
  - Commands received during BRAKE overwrite `target` but do not restart the counter.
  - At exit: target STOP → IDLE; otherwise → RAMP from duty 0.

**Watchdog:**
- The counter clears on every `cmd_valid` and on entry to RAMP.
- In RAMP/RUN, when the counter reaches `TIMEOUT` with no `cmd_valid`: target ← STOP, `timeout_flag` ← 1, → BRAKE.
- Counting is inactive in IDLE and BRAKE.

**Arithmetic and counters:**
- Duty add is done at 11 bits and then saturated, so it never wraps.
- Counters are 32-bit and compare with `==` on the terminal count, with no wrap-around.

## Timing

**Reset** (`rst` sampled high at a `clk` edge):
- State IDLE, target STOP.
- All outputs 0.
- All counters 0.
- Reset overrides every state, including mid-BRAKE and mid-RAMP.

**Latency:**
- Outputs are registered. `cmd_valid` high in cycle N gives new state/pins visible in cycle N+1.
- The first ramp duty (`RAMP_STEP`) appears `RAMP_DIV` cycles after RAMP entry.
- Time from RAMP entry to RUN is ceil(`DUTY_MAX`/`RAMP_STEP`) × `RAMP_DIV` cycles.

**Simultaneous events:**
- `cmd_valid` in the same cycle as the watchdog terminal count: the command wins and the watchdog does not fire.
- `cmd_valid` in the same cycle as the BRAKE exit: the new command determines the exit destination.

**Dead-time guarantee:** between any two different nonzero pin patterns there are at least `DEAD_CYC` cycles with both pin pairs at 00.

## Test plan

All scenarios use `DEAD_CYC`=4, `RAMP_DIV`=3, `RAMP_STEP`=100, `DUTY_MAX`=600, `TIMEOUT`=50.

1. **Reset.** Assert `rst` for 2 cycles in RUN → next cycle all outputs 0, `state`=0.
2. **Ramp from idle.** `cmd_mode`=0010 strobe at cycle 0 →
   - cycle 1: `state`=1, `r_IN`=10, `right_duty`=0;
   - `right_duty` 100, 200, …, 600 every 3 cycles;
   - `state`=2 at cycle 19;
   - `l_IN`=00 and `left_duty`=0 throughout.
3. **Reversal.** In RUN, strobe 1000 →
   - next cycle: `state`=3, pins 00, duties 0 for exactly 4 cycles;
   - then `r_IN`=01 and the ramp restarts at 0.
4. **Retarget during BRAKE.** During BRAKE from UP, strobe 0001 then 0000 → BRAKE still ends 4 cycles after entry and goes to IDLE, with no left drive ever asserted.
5. **Watchdog.** Enter RUN and send no strobes → 50 cycles after the last strobe, `timeout_flag`=1, then BRAKE 4 cycles, then IDLE. The next strobe clears `timeout_flag`.
6. **Code mapping.** Strobe 0111 → `l_IN`=01. Strobe 1111 from IDLE → stays IDLE. Repeated 0010 strobes in RUN → no BRAKE and no watchdog fire.
